keystream_serialiser: RTL and testbench

- Parametrised successor to the single-matrix concat/serialiser.
- Accepts whole ChaCha20 keystream blocks (4x4 word_t state, 64 bytes) into a NUM_BLOCKS-deep ring buffer.
- Emits them as an OUT_BYTES-wide valid/ready byte stream in RFC 8439 order, with per-beat keep and a last marker for truncated final blocks.
- Sits between the ChaCha20 block core and the XOR/Poly1305 datapath.

---
 rtl/keystream_serialiser_pkg.sv | 47 ++++
 rtl/keystream_serialiser_ring.sv | 65 ++++++
 rtl/keystream_serialiser.sv | 176 +++++++++++++++++
 tb/tb_keystream_serialiser.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keystream_serialiser_pkg.sv
// Shared ChaCha20 block types and the byte-ordering helpers used by the
// keystream serialiser and its block ring.
package keystream_serialiser_pkg;

   typedef logic [31:0] word_t;

   localparam int BLOCK_BYTES = 64;
   localparam int BLOCK_WORDS = 16;
   localparam int LEN_W       = 7;

   // word k lives at [k/4][k%4]; flattened, word k occupies bits [32k+31:32k]
   typedef word_t [3:0][3:0] block_t;

   typedef struct packed {
      logic [3:0] word;
      logic [1:0] lane;
   } byte_loc_t;

   // one ring slot: keystream, last-of-message flag, effective length 1..64
   typedef struct packed {
      block_t           blk;
      logic             last;
      logic [LEN_W-1:0] len;
   } slot_t;

   // stream byte b -> word b/4, little-endian byte lane b%4
   function automatic byte_loc_t byte_loc(input logic [5:0] idx);
      byte_loc_t loc;
      loc.word = idx[5:2];
      loc.lane = idx[1:0];
      return loc;
   endfunction

   function automatic logic [7:0] byte_at(input block_t blk, input logic [5:0] idx);
      byte_loc_t loc;
      loc = byte_loc(idx);
      return blk[loc.word[3:2]][loc.word[1:0]][{loc.lane, 3'b000} +: 8];
   endfunction

   // only a final block can be short; 0 and anything past 64 mean a full block
   function automatic logic [LEN_W-1:0] eff_len(input logic last, input logic [LEN_W-1:0] len);
      if (!last || len == '0 || len > LEN_W'(BLOCK_BYTES))
         return LEN_W'(BLOCK_BYTES);
      return len;
   endfunction

endpackage

// File: rtl/keystream_serialiser_ring.sv
// ks_block_ring: NUM_BLOCKS-deep slot store for whole keystream blocks.
// Exposes the head slot and the one behind it so the serialiser can start
// the next block without a bubble.
// Optional: KEYSTREAM_SERIALISER_ZEROISE_EN clears a slot as it retires.
module ks_block_ring
   import keystream_serialiser_pkg::*;
#(
   parameter int NUM_BLOCKS = 2,
   parameter int CNT_W      = $clog2(NUM_BLOCKS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  slot_t            wr_slot,
   input  logic             rd_en,
   output slot_t            rd_slot,
   output slot_t            nx_slot,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

   slot_t            mem [NUM_BLOCKS];
   logic [PTR_W-1:0] wr_ptr, rd_ptr, nx_ptr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(NUM_BLOCKS - 1))
         return '0;
      return p + PTR_W'(1);
   endfunction

   assign nx_ptr  = ptr_inc(rd_ptr);
   assign rd_slot = mem[rd_ptr];
   assign nx_slot = mem[nx_ptr];
   assign full    = (count == CNT_W'(NUM_BLOCKS));
   assign empty   = (count == '0);

   // pointers and occupancy; writes are gated by !full and reads by !empty upstream
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_en) rd_ptr <= nx_ptr;
         case ({wr_en, rd_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // slot storage; write and retire never target the same slot in one cycle
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_slot;
`ifdef KEYSTREAM_SERIALISER_ZEROISE_EN
      if (rd_en) mem[rd_ptr] <= '0;
`endif
   end

endmodule

// File: rtl/keystream_serialiser.sv
// keystream_serialiser: buffers whole ChaCha20 keystream blocks and streams
// them out OUT_BYTES per beat in RFC 8439 byte order, with keep/last for a
// truncated final block. Output beat registers give 1-cycle latency from an
// accept into an empty buffer and no bubble between stored blocks.
// Optional: KEYSTREAM_SERIALISER_ZEROISE_EN zeroes retired slots, masked
// lanes and out_data while idle.
module keystream_serialiser
   import keystream_serialiser_pkg::*;
#(
   parameter int OUT_BYTES  = 4,
   parameter int NUM_BLOCKS = 2,
   parameter int CNT_W      = $clog2(NUM_BLOCKS + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  block_t                 in_block,
   input  logic                   in_last,
   input  logic [6:0]             in_len,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [8*OUT_BYTES-1:0] out_data,
   output logic [OUT_BYTES-1:0]   out_keep,
   output logic                   out_last,
   output logic                   full,
   output logic                   empty,
   output logic [CNT_W-1:0]       count
);

   localparam int OB_SH = $clog2(OUT_BYTES);
   localparam int DW    = 8 * OUT_BYTES;

   typedef struct packed {
      logic [DW-1:0]        data;
      logic [OUT_BYTES-1:0] keep;
      logic                 last;
   } beat_t;

   typedef enum logic [1:0] {IDLE, LOAD_OUT, WAIT} state_e;

   state_e     state;
   logic [5:0] beat;
   slot_t      in_slot, rd_slot, nx_slot, src;
   logic       accept, xfer, final_beat, retire, ld;
   logic [5:0] ld_beat;
   beat_t      nxt;

   function automatic logic [5:0] last_beat(input logic [6:0] len);
      logic [6:0] lm1;
      lm1 = len - 7'd1;
      return lm1[5:0] >> OB_SH;
   endfunction

   // lane n of beat bt carries stream byte bt*OUT_BYTES+n
   function automatic beat_t fmt(input slot_t s, input logic [5:0] bt);
      beat_t      b;
      logic       fin;
      logic [6:0] rem;
      fin    = (bt == last_beat(s.len));
      rem    = s.len & 7'(OUT_BYTES - 1);
      b.last = s.last & fin;
      b.data = '0;
      b.keep = '0;
      for (int n = 0; n < OUT_BYTES; n++) begin
         b.keep[n]        = !(fin && rem != '0) || (n < int'(rem));
         b.data[8*n +: 8] = byte_at(s.blk, 6'(int'(bt) * OUT_BYTES + n));
`ifdef KEYSTREAM_SERIALISER_ZEROISE_EN
         if (!b.keep[n]) b.data[8*n +: 8] = 8'h00;
`endif
      end
      return b;
   endfunction

   assign in_ready   = !full;
   assign accept     = in_valid & in_ready;
   assign xfer       = out_valid & out_ready;
   assign final_beat = (beat == last_beat(rd_slot.len));
   assign retire     = xfer & final_beat;

   assign in_slot.blk  = in_block;
   assign in_slot.last = in_last;
   assign in_slot.len  = eff_len(in_last, in_len);

   ks_block_ring #(
      .NUM_BLOCKS (NUM_BLOCKS),
      .CNT_W      (CNT_W)
   ) u_ring (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (accept),
      .wr_slot (in_slot),
      .rd_en   (retire),
      .rd_slot (rd_slot),
      .nx_slot (nx_slot),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   // choose the beat to present next: same block, next stored block, or a
   // block arriving this cycle (bypassed so the ring write latency is hidden)
   always_comb begin
      ld      = 1'b0;
      ld_beat = '0;
      src     = rd_slot;
      if (state == IDLE) begin
         if (!empty) begin
            ld = 1'b1;
         end else if (accept) begin
            ld  = 1'b1;
            src = in_slot;
         end
      end else if (xfer) begin
         if (!final_beat) begin
            ld      = 1'b1;
            ld_beat = beat + 6'd1;
         end else if (count > CNT_W'(1)) begin
            ld  = 1'b1;
            src = nx_slot;
         end else if (accept) begin
            ld  = 1'b1;
            src = in_slot;
         end
      end
   end

   assign nxt = fmt(src, ld_beat);

   // control FSM with registered output beat; holds stable while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         beat      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_keep  <= '0;
         out_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ld) begin
                  state     <= LOAD_OUT;
                  beat      <= ld_beat;
                  out_valid <= 1'b1;
                  out_data  <= nxt.data;
                  out_keep  <= nxt.keep;
                  out_last  <= nxt.last;
               end
            end
            default: begin
               if (ld) begin
                  state     <= LOAD_OUT;
                  beat      <= ld_beat;
                  out_valid <= 1'b1;
                  out_data  <= nxt.data;
                  out_keep  <= nxt.keep;
                  out_last  <= nxt.last;
               end else if (xfer) begin
                  state     <= IDLE;
                  beat      <= '0;
                  out_valid <= 1'b0;
                  out_keep  <= '0;
                  out_last  <= 1'b0;
`ifdef KEYSTREAM_SERIALISER_ZEROISE_EN
                  out_data  <= '0;
`endif
               end else begin
                  state <= WAIT;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keystream_serialiser.sv
// Directed bench for keystream_serialiser (OUT_BYTES=4, NUM_BLOCKS=2).
module tb_keystream_serialiser;
   import keystream_serialiser_pkg::*;

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, in_last, out_valid, out_ready;
   logic         out_last, full, empty;
   block_t       in_block;
   logic [6:0]   in_len;
   logic [31:0]  out_data;
   logic [3:0]   out_keep;
   logic [1:0]   count;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } ebeat_t;
   ebeat_t q[$];

   keystream_serialiser #(.OUT_BYTES(4), .NUM_BLOCKS(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_block(in_block), .in_last(in_last), .in_len(in_len),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_keep(out_keep), .out_last(out_last), .full(full), .empty(empty),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // stream byte b of the block = base + b
   function automatic block_t mk_block(input logic [7:0] base);
      block_t b;
      for (int k = 0; k < 64; k++)
         b[k/16][(k/4)%4][8*(k%4) +: 8] = base + 8'(k);
      return b;
   endfunction

   function automatic logic [31:0] exp_beat(input logic [7:0] base, input int n);
      return {base + 8'(4*n+3), base + 8'(4*n+2), base + 8'(4*n+1), base + 8'(4*n)};
   endfunction

   task automatic model_block(input logic [7:0] base, input logic last, input int len);
      int L, nb;
      ebeat_t e;
      L  = (!last || len == 0 || len > 64) ? 64 : len;
      nb = (L + 3) / 4;
      for (int bt = 0; bt < nb; bt++) begin
         for (int l = 0; l < 4; l++) begin
            e.k[l]        = (bt*4 + l) < L;
            e.d[8*l +: 8] = base + 8'(bt*4 + l);
`ifdef KEYSTREAM_SERIALISER_ZEROISE_EN
            if (!e.k[l]) e.d[8*l +: 8] = 8'h00;
`endif
         end
         e.l = last && (bt == nb - 1);
         q.push_back(e);
      end
   endtask

   initial begin
      block_t     a;
      int         acc_at, p, nbeats, nlast;
      logic       acc, stall, fin_last;
      logic [31:0] sd;
      logic [3:0]  sk, fin_keep;
      logic        sl;
      logic [7:0]  rb_base [6];
      logic        rb_last [6];
      int          rb_len  [6];

      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_len = '0;
      out_ready = 1'b0; in_block = '0;
      for (int k = 0; k < 16; k++) a[k/4][k%4] = 32'h03020100 + 32'(k) * 32'h04040404;

      // reset state
      step(); step();
      chk("rst_valid", out_valid, 0); chk("rst_last", out_last, 0);
      chk("rst_keep", out_keep, 0);   chk("rst_data", out_data, 0);
      chk("rst_count", count, 0);     chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);       chk("rst_in_ready", in_ready, 1);
      rst = 1'b0;

      // one full block, 16 beats
      in_valid = 1'b1; in_block = a; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("t1_count", count, 1);
      for (int n = 0; n < 16; n++) begin
         chk("t1_valid", out_valid, 1);
         chk("t1_data", out_data, {8'(4*n+3), 8'(4*n+2), 8'(4*n+1), 8'(4*n)});
         chk("t1_keep", out_keep, 4'hF);
         chk("t1_last", out_last, 0);
         step();
      end
      chk("t1_valid_end", out_valid, 0);
      chk("t1_empty_end", empty, 1);
`ifdef KEYSTREAM_SERIALISER_ZEROISE_EN
      chk("t1_idle_data", out_data, 0);
`endif

      // truncated last block, len 13
      in_valid = 1'b1; in_block = a; in_last = 1'b1; in_len = 7'd13;
      step();
      in_valid = 1'b0; in_last = 1'b0; in_len = '0;
      for (int n = 0; n < 4; n++) begin
         chk("t2_valid", out_valid, 1);
         if (n < 3) chk("t2_data", out_data, exp_beat(8'h00, n));
`ifdef KEYSTREAM_SERIALISER_ZEROISE_EN
         else chk("t2_data_fin", out_data, 32'h0000000C);
`else
         else chk("t2_data_fin", out_data, 32'h0F0E0D0C);
`endif
         chk("t2_keep", out_keep, (n == 3) ? 4'b0001 : 4'hF);
         chk("t2_last", out_last, (n == 3) ? 1'b1 : 1'b0);
         step();
      end
      chk("t2_valid_end", out_valid, 0);

      // fill while stalled, then drain with no bubble
      out_ready = 1'b0; in_valid = 1'b1; in_block = mk_block(8'h40);
      step();
      chk("t3_count1", count, 1); chk("t3_in_ready1", in_ready, 1);
      in_block = mk_block(8'h80);
      step();
      chk("t3_count2", count, 2); chk("t3_full", full, 1); chk("t3_in_ready0", in_ready, 0);
      chk("t3_data_hold0", out_data, exp_beat(8'h40, 0));
      in_block = mk_block(8'hC0);
      step();
      chk("t3_count_still", count, 2); chk("t3_valid_hold", out_valid, 1);
      chk("t3_data_hold1", out_data, exp_beat(8'h40, 0));
      out_ready = 1'b1; acc_at = -1;
      for (int i = 0; i < 48; i++) begin
         chk("t3_valid", out_valid, 1);
         chk("t3_data", out_data, exp_beat(8'(8'h40 * (i/16 + 1)), i % 16));
         acc = in_valid & in_ready;
         step();
         if (acc) begin in_valid = 1'b0; acc_at = i; end
      end
      chk("t3_accept_at", acc_at, 16);
      chk("t3_valid_end", out_valid, 0);
      chk("t3_empty_end", empty, 1);

      // random out_ready against a byte-stream model
      rb_base = '{8'h11, 8'h37, 8'h5D, 8'h83, 8'hA9, 8'hCF};
      rb_last = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      rb_len  = '{0, 13, 0, 64, 0, 7};
      for (int j = 0; j < 6; j++) model_block(rb_base[j], rb_last[j], rb_len[j]);
      p = 0; stall = 1'b0; sd = '0; sk = '0; sl = 1'b0;
      for (int cyc = 0; cyc < 3000 && q.size() > 0; cyc++) begin
         if (!in_valid && p < 6) begin
            in_valid = 1'b1; in_block = mk_block(rb_base[p]);
            in_last = rb_last[p]; in_len = 7'(rb_len[p]);
         end
         out_ready = 1'($urandom_range(0, 1));
         if (stall) begin
            chk("t4_stall_valid", out_valid, 1);
            chk("t4_stall_data", {out_data, out_keep, out_last}, {sd, sk, sl});
         end
         if (out_valid && out_ready) begin
            chk("t4_data", out_data, q[0].d);
            chk("t4_keep", out_keep, q[0].k);
            chk("t4_last", out_last, q[0].l);
            void'(q.pop_front());
         end
         stall = out_valid & !out_ready;
         sd = out_data; sk = out_keep; sl = out_last;
         acc = in_valid & in_ready;
         step();
         if (acc) begin in_valid = 1'b0; p++; end
      end
      chk("t4_all_beats", q.size(), 0);
      chk("t4_all_blocks", p, 6);
      in_last = 1'b0; in_len = '0; out_ready = 1'b1;
      step(); step();
      chk("t4_empty_end", empty, 1);

      // reset mid-block discards everything
      in_valid = 1'b1; in_block = mk_block(8'h00);
      step();
      in_block = mk_block(8'h40);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("t5_beat5", out_data, exp_beat(8'h00, 5));
      chk("t5_count_pre", count, 2);
      rst = 1'b1;
      step();
      chk("t5_valid", out_valid, 0); chk("t5_count", count, 0);
      chk("t5_empty", empty, 1);     chk("t5_full", full, 0);
      rst = 1'b0; in_valid = 1'b1; in_block = mk_block(8'h80);
      step();
      in_valid = 1'b0;
      chk("t5_new_beat0", out_data, exp_beat(8'h80, 0));
      step();
      chk("t5_new_beat1", out_data, exp_beat(8'h80, 1));
      for (int i = 0; i < 15; i++) step();
      chk("t5_valid_end", out_valid, 0);
      chk("t5_empty_end", empty, 1);

      // in_len 0 and >64 on a last block mean a full 64 bytes
      for (int t = 0; t < 2; t++) begin
         in_valid = 1'b1; in_block = mk_block(8'h20); in_last = 1'b1;
         in_len = (t == 0) ? 7'd0 : 7'd100;
         step();
         in_valid = 1'b0; in_last = 1'b0; in_len = '0;
         nbeats = 0; nlast = 0; fin_keep = '0; fin_last = 1'b0;
         for (int c = 0; c < 40 && out_valid; c++) begin
            nbeats++;
            if (out_last) nlast++;
            fin_keep = out_keep; fin_last = out_last;
            step();
         end
         chk("t6_beats", nbeats, 16);
         chk("t6_nlast", nlast, 1);
         chk("t6_fin_keep", fin_keep, 4'hF);
         chk("t6_fin_last", fin_last, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
